// File: rtl/writeback.sv
// Writeback (_w) stage: registers the memory-stage results and drives the register-file write, PC redirect and forwarding value.
// Optional retired-instruction counter is compiled in when WB_INSTRET_EN is defined.
module writeback (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write_m,
  input  logic [31:0] pc_next_addr_m,
  input  logic        rd_write_m,
  input  logic [1:0]  rd_write_src_m,
  input  logic [4:0]  rd_m,
  input  logic [31:0] pc_m,
  input  logic [31:0] alu_res_m,
  input  logic [31:0] mem_read_data_m,
  input  logic        stall_w,
  input  logic        flush_w,
  output logic        rd_write_w,
  output logic [4:0]  rd_w,
  output logic [31:0] rd_data_w,
  output logic        pc_write_w,
  output logic [31:0] pc_next_addr_w,
  output logic        valid_w,
  output logic [63:0] instret_w
);

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_MEM  = 2'b01;
  localparam logic [1:0] SRC_PC4  = 2'b10;
  localparam logic [1:0] SRC_NONE = 2'b11;

  logic        valid_q;
  logic        pc_write_q;
  logic        rd_write_q;
  logic [1:0]  rd_write_src_q;
  logic [4:0]  rd_q;
  logic [31:0] pc_q;
  logic [31:0] alu_res_q;
  logic [31:0] mem_read_data_q;
  logic [31:0] pc_next_addr_q;

  // A flush only clears control fields; data fields are left as-is since nothing consumes them without valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= 1'b0;
      pc_write_q      <= 1'b0;
      rd_write_q      <= 1'b0;
      rd_write_src_q  <= SRC_ALU;
      rd_q            <= '0;
      pc_q            <= '0;
      alu_res_q       <= '0;
      mem_read_data_q <= '0;
      pc_next_addr_q  <= '0;
    end else if (flush_w) begin
      valid_q        <= 1'b0;
      pc_write_q     <= 1'b0;
      rd_write_q     <= 1'b0;
      rd_write_src_q <= SRC_ALU;
    end else if (!stall_w) begin
      valid_q         <= 1'b1;
      pc_write_q      <= pc_write_m;
      rd_write_q      <= rd_write_m;
      rd_write_src_q  <= rd_write_src_m;
      rd_q            <= rd_m;
      pc_q            <= pc_m;
      alu_res_q       <= alu_res_m;
      mem_read_data_q <= mem_read_data_m;
      pc_next_addr_q  <= pc_next_addr_m;
    end
  end

  always_comb begin
    rd_data_w = '0;
    case (rd_write_src_q)
      SRC_ALU:  rd_data_w = alu_res_q;
      SRC_MEM:  rd_data_w = mem_read_data_q;
      SRC_PC4:  rd_data_w = pc_q + 32'd4;
      SRC_NONE: rd_data_w = '0;
      default:  rd_data_w = '0;
    endcase
  end

  // x0 writes and the reserved select never reach the register file.
  assign rd_write_w     = valid_q & rd_write_q & (rd_q != 5'd0) & (rd_write_src_q != SRC_NONE);
  assign rd_w           = rd_q;
  assign pc_write_w     = valid_q & pc_write_q;
  assign pc_next_addr_w = pc_next_addr_q;
  assign valid_w        = valid_q;

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q;

  // Every unstalled, unflushed edge out of reset retires the instruction being captured.
  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (!stall_w && !flush_w) begin
      instret_q <= instret_q + 64'd1;
    end
  end

  assign instret_w = instret_q;
`else
  assign instret_w = '0;
`endif

endmodule
